soc_pio_status_capture: RTL and testbench

SOC_PIO_STATUS_CAPTURE -- requirements
Module: soc_pio_status_capture

---
 rtl/soc_pio_pkg.sv | 32 +++
 rtl/soc_pio_sync.sv | 40 ++++
 rtl/soc_pio_status_capture.sv | 121 ++++++++++++
 tb/tb_soc_pio_status_capture.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/soc_pio_pkg.sv
// Shared constants and helpers for the PIO status-capture block.
package soc_pio_pkg;

  // Register map
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_ZERO = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Edge-type encodings for EDGE_TYPE
  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // Interrupt-mode encodings for IRQ_MODE
  localparam int unsigned IRQ_LEVEL = 0;
  localparam int unsigned IRQ_EDGE  = 1;

  // Per-bit edge detect on a full 32-bit word; callers use the low bits.
  function automatic logic [31:0] edge_detect(input int unsigned edge_type,
                                              input logic [31:0]  cur,
                                              input logic [31:0]  prev);
    logic [31:0] result;
    case (edge_type)
      EDGE_RISE: result = cur & ~prev;
      EDGE_FALL: result = ~cur & prev;
      default:   result = cur ^ prev;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/soc_pio_sync.sv
// Multi-flop input synchroniser; STAGES = 0 is a straight pass-through.
module soc_pio_sync #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  if (STAGES == 0) begin : g_bypass
    assign q = d;
  end else begin : g_flops
    logic [WIDTH-1:0] stage_q [STAGES];
    logic [WIDTH-1:0] stage_d [STAGES];

    // Shift chain: stage 0 samples the input, each later stage the one before
    always_comb begin
      stage_d[0] = d;
      for (int unsigned i = 1; i < STAGES; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Synchroniser flops with synchronous clear
    always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        if (!reset_n) begin
          stage_q[i] <= '0;
        end else begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign q = stage_q[STAGES-1];
  end

endmodule

// File: rtl/soc_pio_status_capture.sv
// PIO status capture: synchronised inputs, edge capture with
// write-1-to-clear, interrupt mask and registered read port.
module soc_pio_status_capture
  import soc_pio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned EDGE_TYPE   = 2,
  parameter int unsigned IRQ_MODE    = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  input  logic [DATA_WIDTH-1:0] in_port,
  output logic [31:0]           readdata,
  output logic                  irq
);

  // Edge detection is held off until the synchroniser and prev_data have
  // both been refilled from in_port after reset.
  localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
  localparam int unsigned WARM_W      = $clog2(WARM_CYCLES + 1);

  logic [DATA_WIDTH-1:0] sync_data;
  logic [DATA_WIDTH-1:0] prev_data_q,   prev_data_d;
  logic [DATA_WIDTH-1:0] edgecapture_q, edgecapture_d;
  logic [DATA_WIDTH-1:0] irqmask_q,     irqmask_d;
  logic [WARM_W-1:0]     warm_q,        warm_d;
  logic [31:0]           readdata_q,    readdata_d;
  logic                  irq_q,         irq_d;

  logic                  wr_en;
  logic                  warm_done;
  logic [DATA_WIDTH-1:0] wr_bits;
  logic [DATA_WIDTH-1:0] edge_vec;
  logic [31:0]           cur_ext;
  logic [31:0]           prev_ext;
  logic [31:0]           edge_ext;

  soc_pio_sync #(
    .WIDTH  (DATA_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (in_port),
    .q       (sync_data)
  );

  // Write decode, warm-up counter and gated edge detection
  always_comb begin
    wr_en     = chipselect && !write_n;
    wr_bits   = writedata[DATA_WIDTH-1:0];
    warm_done = (warm_q == WARM_W'(WARM_CYCLES));
    warm_d    = warm_done ? warm_q : warm_q + 1'b1;

    cur_ext                   = '0;
    cur_ext[DATA_WIDTH-1:0]   = sync_data;
    prev_ext                  = '0;
    prev_ext[DATA_WIDTH-1:0]  = prev_data_q;
    edge_ext                  = edge_detect(EDGE_TYPE, cur_ext, prev_ext);
    edge_vec                  = warm_done ? edge_ext[DATA_WIDTH-1:0] : '0;
  end

  // Register next-state: clear applied first so a same-cycle edge wins
  always_comb begin
    prev_data_d   = sync_data;
    edgecapture_d = edgecapture_q;
    irqmask_d     = irqmask_q;
    if (wr_en && (address == ADDR_EDGE)) begin
      edgecapture_d = edgecapture_q & ~wr_bits;
    end
    edgecapture_d = edgecapture_d | edge_vec;
    if (wr_en && (address == ADDR_MASK)) begin
      irqmask_d = wr_bits;
    end
  end

  // Read mux and interrupt, both from pre-write register values
  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[DATA_WIDTH-1:0] = sync_data;
      ADDR_MASK: readdata_d[DATA_WIDTH-1:0] = irqmask_q;
      ADDR_EDGE: readdata_d[DATA_WIDTH-1:0] = edgecapture_q;
      default:   readdata_d = '0;
    endcase

    if (IRQ_MODE == IRQ_EDGE) begin
      irq_d = |(edgecapture_q & irqmask_q);
    end else begin
      irq_d = |(sync_data & irqmask_q);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_data_q   <= '0;
      edgecapture_q <= '0;
      irqmask_q     <= '0;
      warm_q        <= '0;
      readdata_q    <= '0;
      irq_q         <= 1'b0;
    end else begin
      prev_data_q   <= prev_data_d;
      edgecapture_q <= edgecapture_d;
      irqmask_q     <= irqmask_d;
      warm_q        <= warm_d;
      readdata_q    <= readdata_d;
      irq_q         <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_soc_pio_status_capture.sv
// Directed bench: instance A is 32-bit rising-edge / edge-irq,
// instance B is 8-bit any-edge / level-irq. Bus inputs are shared.
module tb_soc_pio_status_capture;
  import soc_pio_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port_a;
  logic [7:0]  in_port_b;
  logic [31:0] readdata_a;
  logic [31:0] readdata_b;
  logic        irq_a;
  logic        irq_b;

  int unsigned n_total;
  int unsigned n_bad;

  soc_pio_status_capture #(
    .DATA_WIDTH  (32),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (0),
    .IRQ_MODE    (1)
  ) u_dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port_a),
    .readdata   (readdata_a),
    .irq        (irq_a)
  );

  soc_pio_status_capture #(
    .DATA_WIDTH  (8),
    .SYNC_STAGES (2),
    .EDGE_TYPE   (2),
    .IRQ_MODE    (0)
  ) u_dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port_b),
    .readdata   (readdata_b),
    .irq        (irq_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; return 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // One-cycle write; on return readdata holds the pre-write value
  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    address    = addr;
    chipselect = 1'b1;
    write_n    = 1'b0;
    writedata  = data;
    tick();
    write_n    = 1'b1;
  endtask

  initial begin
    n_total    = 0;
    n_bad      = 0;
    reset_n    = 1'b0;
    address    = ADDR_EDGE;
    chipselect = 1'b1;
    write_n    = 1'b1;
    writedata  = '0;
    in_port_a  = 32'hFFFF_FFFF;
    in_port_b  = 8'hFF;

    // Reset state with inputs held high
    repeat (3) tick();
    check_eq("rst_rd_a", readdata_a, 32'h0);
    check_eq("rst_irq_a", {31'b0, irq_a}, 32'h0);
    check_eq("rst_rd_b", readdata_b, 32'h0);
    check_eq("rst_irq_b", {31'b0, irq_b}, 32'h0);

    // Inputs high across release: no edge captured during warm-up or after
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("warm_edge_a", readdata_a, 32'h0);
      check_eq("warm_irq_a", {31'b0, irq_a}, 32'h0);
      check_eq("warm_edge_b", readdata_b, 32'h0);
    end
    address = ADDR_DATA;
    tick();
    check_eq("data_a", readdata_a, 32'hFFFF_FFFF);
    check_eq("data_b", readdata_b, 32'h0000_00FF);

    // Rising edge on bit0 with mask 0x1
    in_port_a = 32'h0;
    in_port_b = 8'h0;
    repeat (4) tick();
    bus_write(ADDR_MASK, 32'h1);
    address = ADDR_EDGE;
    tick();
    check_eq("fall_ignored", readdata_a, 32'h0);
    in_port_a = 32'h1;
    tick();
    tick();
    tick();
    check_eq("rise_early", readdata_a, 32'h0);
    check_eq("rise_irq_early", {31'b0, irq_a}, 32'h0);
    tick();
    check_eq("rise_cap", readdata_a, 32'h1);
    check_eq("rise_irq", {31'b0, irq_a}, 32'h1);
    bus_write(ADDR_EDGE, 32'h1);
    check_eq("clr_prewrite", readdata_a, 32'h1);
    check_eq("clr_irq_hold", {31'b0, irq_a}, 32'h1);
    tick();
    check_eq("clr_edge", readdata_a, 32'h0);
    check_eq("clr_irq", {31'b0, irq_a}, 32'h0);

    // Clear and set of bit4 in the same cycle: set wins
    in_port_a = 32'h11;
    tick();
    tick();
    address   = ADDR_EDGE;
    write_n   = 1'b0;
    writedata = 32'h10;
    tick();
    write_n   = 1'b1;
    tick();
    check_eq("collide", readdata_a, 32'h10);
    bus_write(ADDR_EDGE, 32'h10);
    tick();
    check_eq("clr_bit4", readdata_a, 32'h0);

    // Level-mode interrupt on instance B
    bus_write(ADDR_MASK, 32'h8);
    in_port_b = 8'h08;
    tick();
    tick();
    check_eq("lvl_early", {31'b0, irq_b}, 32'h0);
    tick();
    check_eq("lvl_set", {31'b0, irq_b}, 32'h1);
    address = ADDR_DATA;
    tick();
    check_eq("lvl_data_b", readdata_b, 32'h08);
    in_port_b = 8'h0;
    tick();
    tick();
    check_eq("lvl_hold", {31'b0, irq_b}, 32'h1);
    tick();
    check_eq("lvl_clr", {31'b0, irq_b}, 32'h0);

    // Mask width truncation and reserved address
    bus_write(ADDR_MASK, 32'hFFFF_FFFF);
    check_eq("mask_prewrite_a", readdata_a, 32'h8);
    check_eq("mask_prewrite_b", readdata_b, 32'h8);
    tick();
    check_eq("mask_full_a", readdata_a, 32'hFFFF_FFFF);
    check_eq("mask_width_b", readdata_b, 32'h0000_00FF);
    bus_write(ADDR_ZERO, 32'hFFFF_FFFF);
    tick();
    check_eq("addr1_a", readdata_a, 32'h0);
    check_eq("addr1_b", readdata_b, 32'h0);

    // Reset pulse mid-operation with edgecapture = 0x3 and irq high
    in_port_a = 32'h10;
    repeat (4) tick();
    in_port_a = 32'h13;
    address = ADDR_EDGE;
    repeat (4) tick();
    check_eq("pre_rst_edge", readdata_a, 32'h3);
    check_eq("pre_rst_irq", {31'b0, irq_a}, 32'h1);
    reset_n = 1'b0;
    tick();
    check_eq("mid_rst_irq", {31'b0, irq_a}, 32'h0);
    check_eq("mid_rst_rd", readdata_a, 32'h0);
    reset_n = 1'b1;
    tick();
    check_eq("mid_rst_edge", readdata_a, 32'h0);
    address = ADDR_MASK;
    tick();
    check_eq("mid_rst_mask", readdata_a, 32'h0);
    address = ADDR_EDGE;
    repeat (5) tick();
    check_eq("mid_rst_warm", readdata_a, 32'h0);
    check_eq("mid_rst_irq2", {31'b0, irq_a}, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
